// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the CPU control unit
// (port 0) and a DMA/debug master (port 1). Transactions are serialised
// through IDLE -> BUSY -> ACK; read data and the ack pulse are registered.
// Optional feature macro: MEM_ARB_TIMEOUT_EN (adds bus_err_o and TIMEOUT).
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner on a request
// BUSY  | memory strobe asserted from latched op/addr/wdata, wait mem_ready
// ACK   | one-cycle ack to the winner, strobes low, then back to IDLE
module mem_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int CPU_PRIO     = 1,
   parameter int STARVE_LIMIT = 4
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   parameter int TIMEOUT      = 64
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_rd_i,
   input  logic          cpu_wr_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic [DW-1:0] cpu_rdata_o,
   output logic          cpu_ack_o,
   output logic          cpu_wait_o,
   input  logic          dma_rd_i,
   input  logic          dma_wr_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   output logic [DW-1:0] dma_rdata_o,
   output logic          dma_ack_o,
`ifdef MEM_ARB_TIMEOUT_EN
   output logic          bus_err_o,
`endif
   output logic          mem_rd_o,
   output logic          mem_wr_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ready_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t        state_q;
   logic          owner_q;       // 0 = CPU, 1 = DMA
   logic          last_grant_q;
   logic          op_wr_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [3:0]    starve_q, starve_d;
   logic          mem_rd_q, mem_wr_q;
   logic          cpu_ack_q, dma_ack_q;
   logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
   logic          cpu_req, dma_req, grant_dma_d;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] tmo_q;
   logic          bus_err_q;
   assign bus_err_o = bus_err_q;
`endif

   assign cpu_req = cpu_rd_i | cpu_wr_i;
   assign dma_req = dma_rd_i | dma_wr_i;

   // Winner selection for the IDLE cycle plus the starvation counter update.
   always_comb begin
      grant_dma_d = 1'b0;
      if (CPU_PRIO != 0)
         grant_dma_d = dma_req & (~cpu_req | (starve_q == STARVE_MAX));
      else
         grant_dma_d = dma_req & (~cpu_req | ~last_grant_q);
      starve_d = starve_q;
      if (grant_dma_d)
         starve_d = 4'd0;
      else if (dma_req && (starve_q != STARVE_MAX))
         starve_d = starve_q + 4'd1;
   end

   // Sequencer: latches the granted access and produces all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;   // DMA, so the CPU wins the first tie
         op_wr_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         starve_q     <= 4'd0;
         mem_rd_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         tmo_q        <= '0;
         bus_err_q    <= 1'b0;
`endif
      end else begin
         cpu_ack_q <= 1'b0;
         dma_ack_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         bus_err_q <= 1'b0;
`endif
         case (state_q)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  owner_q      <= grant_dma_d;
                  last_grant_q <= grant_dma_d;
                  starve_q     <= starve_d;
                  op_wr_q      <= grant_dma_d ? dma_wr_i : cpu_wr_i;
                  addr_q       <= grant_dma_d ? dma_addr_i : cpu_addr_i;
                  wdata_q      <= grant_dma_d ? dma_wdata_i : cpu_wdata_i;
                  mem_wr_q     <= grant_dma_d ? dma_wr_i : cpu_wr_i;
                  mem_rd_q     <= grant_dma_d ? ~dma_wr_i : ~cpu_wr_i;
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_q        <= '0;
`endif
                  state_q      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ready_i) begin
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  if (!op_wr_q) begin
                     if (owner_q) dma_rdata_q <= mem_rdata_i;
                     else         cpu_rdata_q <= mem_rdata_i;
                  end
                  cpu_ack_q <= ~owner_q;
                  dma_ack_q <= owner_q;
                  state_q   <= ST_ACK;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tmo_q == TMO_LAST) begin
                  mem_rd_q  <= 1'b0;
                  mem_wr_q  <= 1'b0;
                  if (owner_q) dma_rdata_q <= '0;
                  else         cpu_rdata_q <= '0;
                  cpu_ack_q <= ~owner_q;
                  dma_ack_q <= owner_q;
                  bus_err_q <= 1'b1;
                  state_q   <= ST_ACK;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            ST_ACK:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mem_rd_o    = mem_rd_q;
   assign mem_wr_o    = mem_wr_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign dma_ack_o   = dma_ack_q;
   assign cpu_rdata_o = cpu_rdata_q;
   assign dma_rdata_o = dma_rdata_q;
   assign cpu_wait_o  = cpu_req & ~cpu_ack_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between two requesters: the CPU control unit (port 0) and a DMA/debug master (port 1).
- Sits between both masters and the memory.
- Serialises transactions and returns a registered read data word plus a one-cycle ack to the granted master.
- Raises cpu_wait so the control unit holds its current state while a CPU access is pending.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- CPU_PRIO, 1: 1 = CPU has fixed priority, subject to the starvation limit; 0 = round-robin.
- STARVE_LIMIT, 4: consecutive CPU grants while DMA is waiting before DMA is forced; range 1..15.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd, cpu_wr  in  1 each  CPU read/write request.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  registered read data for CPU.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- cpu_wait  out  1  CPU request pending, not yet acked.
- dma_rd, dma_wr, dma_addr, dma_wdata, dma_rdata, dma_ack  same meaning, port 1.
- mem_rd, mem_wr  out  1 each  memory strobes.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- mem_ready  in  1  memory completes the current access this cycle.

Behaviour:
- Reset (rst_n low, async), all outputs 0:
  - state=IDLE, last_grant=DMA so CPU wins the first tie, starve_cnt=0.
  - All mem_* outputs, both rdata, both ack and cpu_wait are 0.
- Request rules:
  - A request is rd|wr. The master holds addr, wdata and strobe stable until it sees ack.
  - rd and wr asserted together are treated as a write.
  - Dropping a request before ack is illegal. The arbiter completes the latched access anyway and acks it.
- Address and data latching: addr, wdata and op type are latched into internal registers on the grant edge. mem_* outputs are driven only from these latched registers.
- State machine:
  - IDLE: if any request is present, arbitrate, latch the winner, go to BUSY. Otherwise stay in IDLE.
  - BUSY: mem_rd or mem_wr is asserted per the latched op, with mem_addr and mem_wdata valid. Stay in BUSY while mem_ready=0. When mem_ready=1, capture mem_rdata into the winner's rdata (reads only; rdata is unchanged on writes), go to ACK.
  - ACK: winner's ack=1 for exactly this cycle; mem strobes are 0. Return to IDLE.
- Latency: with zero-wait memory (mem_ready=1 in the first BUSY cycle), ack arrives 2 cycles after the IDLE cycle that sampled the request. Each mem_ready=0 cycle adds one cycle. A new grant is at most every 3 cycles.
- Arbitration:
  - CPU_PRIO=0, round-robin: on a tie, grant the master not equal to last_grant. A single requester always wins.
  - CPU_PRIO=1, fixed priority: CPU wins ties. starve_cnt increments on each CPU grant made while dma was requesting, and clears on any DMA grant. When starve_cnt==STARVE_LIMIT and DMA is requesting, DMA is granted even if CPU is also requesting.
  - starve_cnt saturates at STARVE_LIMIT.
- cpu_wait: combinational (cpu_rd|cpu_wr) & ~cpu_ack.
- Reset mid-operation: the access is abandoned, strobes drop asynchronously, and no ack is issued.

Optional Feature:
- MEM_ARB_TIMEOUT_EN adds output bus_err (1 bit) and parameter TIMEOUT (default 64).
- With the macro:
  - A counter runs in BUSY and clears on entry to BUSY.
  - If it reaches TIMEOUT with mem_ready still 0, the access is aborted and the FSM goes to ACK.
  - The ack is issued with rdata=0 and bus_err=1 for that same cycle, letting the control unit take its exception path.
- Without the macro: no bus_err port, no counter; BUSY waits indefinitely.

Test Plan:
- CPU-only read: cpu_rd=1, addr=0x10, memory returns 0xDEADBEEF with mem_ready in the first BUSY cycle → mem_rd on cycle 1, cpu_ack on cycle 2, cpu_rdata=0xDEADBEEF, cpu_wait low after ack.
- Wait states: DMA write addr=0x20, wdata=0x1234, mem_ready delayed 3 cycles → mem_wr and mem_addr held stable 4 cycles, dma_ack 1 cycle later, dma_rdata unchanged.
- Contention with CPU_PRIO=1, STARVE_LIMIT=4: both masters request continuously → grant order CPU,CPU,CPU,CPU,DMA, then repeats.
- Contention with CPU_PRIO=0: both masters request continuously → strict alternation CPU,DMA,CPU,DMA; first grant is CPU.
- Async reset: rst_n low mid-BUSY → mem_rd/mem_wr drop immediately, no ack pulse, next grant after release goes to CPU.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=8, mem_ready never asserted → ack after 8 BUSY cycles with bus_err=1 and rdata=0.
